burst_mem: RTL and testbench
============================

BURST_MEM -- requirements
Module: burst_mem

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 10, address width in bits.
REQ-003 Parameter DEPTH, default 1024, number of words; valid range 2 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter LEN_W, default 4, burst-length field width; a burst is req_len+1 beats.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  burst request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_wr  in  1  1 = write burst, 0 = read burst.
REQ-010 req_addr  in  ADDR_W  start address.
REQ-011 req_len  in  LEN_W  beats minus one.
REQ-012 wr_data  in  DATA_W  write beat data.
REQ-013 wr_valid  in  1  write beat present.
REQ-014 wr_ready  out  1  write beat accepted when wr_valid is also high.
REQ-015 rd_data  out  DATA_W  read beat data, registered.
REQ-016 rd_valid  out  1  rd_data carries a read beat this cycle; no backpressure.
REQ-017 done  out  1  one-cycle pulse at burst completion.
REQ-018 err  out  1  qualified by done; 1 = burst rejected for out-of-range start address.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 The block SHALL implement states IDLE, WR, RD, RESP; req_ready = 1 only in IDLE.
REQ-021 A request is accepted on a cycle with req_valid && req_ready; addr, remaining-beat count (req_len) and req_wr are captured.
REQ-022 On acceptance with req_addr >= DEPTH: no memory access, next state RESP with err = 1.
REQ-023 Otherwise: next state WR if req_wr = 1, else RD.
REQ-024 WR: wr_ready = 1 in every WR cycle; each wr_valid cycle writes wr_data to mem[addr], increments addr, decrements count; cycles without wr_valid stall with no change.
REQ-025 RD: one read is issued per cycle with no stalls; rd_data = mem[addr] and rd_valid = 1 appear on the cycle after issue; addr increments per issue.
REQ-026 Read latency: first rd_valid occurs 2 cycles after the acceptance edge; beats appear on consecutive cycles in address order.
REQ-027 Address wrap: an increment from DEPTH-1 SHALL go to 0, never to a value >= DEPTH.
REQ-028 The beat issued or written with count = 0 is the last; the next state is then RESP.
REQ-029 RESP lasts exactly one cycle: done = 1 and err valid; the last read beat's rd_valid coincides with this cycle; next state is IDLE.
REQ-030 A new request SHALL NOT be accepted before the cycle after done, so the minimum request-to-request spacing for a len=0 burst is 3 cycles.
REQ-031 rd_data SHALL hold its last value when rd_valid = 0.
REQ-032 wr_valid outside WR SHALL be ignored; req_valid outside IDLE SHALL be ignored, and that request is not queued.
REQ-033 Memory array contents are not initialised and SHALL persist across bursts.

Reset
REQ-034 On rst high, asynchronously: state = IDLE, req_ready = 1, wr_ready = 0, rd_valid = 0, rd_data = 0, done = 0, err = 0, busy = 0.
REQ-035 Reset mid-burst SHALL abort the burst with no done pulse; beats already written remain in memory.
REQ-036 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-037 Write addr 0x010, len 3, data 0xA1..0xA4 with wr_valid continuous -> 4 writes, done on cycle 5 after acceptance, err = 0; read back -> rd_valid on cycles 2-5 with 0xA1..0xA4.
REQ-038 Write addr 0x3FE, len 3 (DEPTH 1024) -> words land at 0x3FE, 0x3FF, 0x000, 0x001; a read burst at the same address returns them in that order.
REQ-039 Request with addr 0x400 and DEPTH 1024 -> no memory change, done = 1 and err = 1 on the cycle after acceptance.
REQ-040 Write burst len 1 with wr_valid low for 3 cycles between beats -> wr_ready held at 1, two writes only, done after the second beat.
REQ-041 rst asserted during beat 2 of a 4-beat write -> outputs go to reset values immediately, no done; a later read shows only beats 0-1 updated.
REQ-042 req_valid held high during a read burst -> req_ready = 0 until the cycle after done, then the held request is accepted.

Source files
------------

// File: rtl/burst_mem.sv
// rtl/burst_mem.sv - single-port burst memory with write/read bursts and completion response
//
// Purpose: accepts one burst request at a time, streams write beats into or
// read beats out of an internal word array, then pulses done (with err) for
// one cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      burst request handshake (ready only when idle)
//   req_wr, req_addr, req_len  direction, start address, beats minus one
//   wr_data/wr_valid/wr_ready  write beat stream (ready throughout a write burst)
//   rd_data/rd_valid         registered read beat stream, no backpressure
//   done, err                one-cycle completion pulse; err flags a rejected start address
//   busy                     high whenever a burst is in progress
module burst_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // One extra bit so DEPTH == 2**ADDR_W compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic              err_q;
    logic              addr_oob;
    logic              wr_beat;
    logic [ADDR_W-1:0] addr_next;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign addr_oob  = {1'b0, req_addr} >= DEPTH_X;
    assign wr_beat   = (state == S_WR) && wr_valid;
    assign addr_next = (addr == ADDR_LAST) ? '0 : addr + 1'b1;

    assign req_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_WR);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_RESP);
    assign err       = (state == S_RESP) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            count    <= '0;
            err_q    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            // Read beat is issued in an RD cycle and presented one cycle later,
            // so the final beat lines up with the RESP cycle.
            rd_valid <= (state == S_RD);
            if (state == S_RD) begin
                rd_data <= mem[addr];
            end

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr  <= req_addr;
                        count <= req_len;
                        err_q <= addr_oob;
                        if (addr_oob) begin
                            state <= S_RESP;
                        end else if (req_wr) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (wr_valid) begin
                        addr  <= addr_next;
                        count <= count - 1'b1;
                        if (count == '0) begin
                            state <= S_RESP;
                        end
                    end
                end
                S_RD: begin
                    addr  <= addr_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= S_RESP;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset so contents survive reset; state is forced to IDLE
    // asynchronously, which blocks writes while rst is high.
    always_ff @(posedge clk) begin
        if (wr_beat) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_burst_mem.sv
// tb/tb_burst_mem.sv - self-checking bench for burst_mem against a word-array model
module tb_burst_mem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1024;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] model [0:DEPTH-1];

    burst_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a request in the current cycle; returns in the cycle after acceptance.
    task automatic issue(input bit wr, input int a, input int len);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = ADDR_W'(a);
        req_len   = LEN_W'(len);
        check("req_ready_idle", req_ready, 1);
        check("busy_idle", busy, 0);
        step();
        req_valid = 1'b0;
    endtask

    task automatic check_reject();
        check("rej_done", done, 1);
        check("rej_err", err, 1);
        step();
        check("rej_done_clr", done, 0);
        check("rej_ready", req_ready, 1);
    endtask

    // data_base < 0: random data; gap < 0: random 0..2 idle cycles between beats.
    task automatic do_write(input int a, input int len, input int data_base, input int gap);
        int g;
        logic [DATA_W-1:0] d;
        issue(1'b1, a, len);
        if (a >= DEPTH) begin
            check_reject();
            return;
        end
        for (int i = 0; i <= len; i++) begin
            g = (i == 0) ? 0 : ((gap < 0) ? $urandom_range(0, 2) : gap);
            repeat (g) begin
                wr_valid = 1'b0;
                check("wr_ready_stall", wr_ready, 1);
                check("wr_done_early", done, 0);
                step();
            end
            d = (data_base < 0) ? DATA_W'($urandom) : DATA_W'(data_base + i);
            wr_valid = 1'b1;
            wr_data  = d;
            check("wr_ready_beat", wr_ready, 1);
            check("wr_done_early", done, 0);
            model[(a + i) % DEPTH] = d;
            step();
        end
        wr_valid = 1'b0;
        check("wr_done", done, 1);
        check("wr_err", err, 0);
        check("wr_ready_resp", wr_ready, 0);
        step();
        check("wr_done_clr", done, 0);
        check("wr_idle_ready", req_ready, 1);
    endtask

    task automatic read_beats(input int a, input int len);
        logic [DATA_W-1:0] last;
        last = '0;
        for (int i = 0; i <= len; i++) begin
            step();
            last = model[(a + i) % DEPTH];
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, last);
            check("rd_done", done, (i == len) ? 1 : 0);
            if (i == len) check("rd_err", err, 0);
        end
        step();
        check("rd_valid_end", rd_valid, 0);
        check("rd_data_hold", rd_data, last);
        check("rd_done_clr", done, 0);
    endtask

    task automatic do_read(input int a, input int len);
        issue(1'b0, a, len);
        if (a >= DEPTH) begin
            check_reject();
            return;
        end
        check("rd_first_latency", rd_valid, 0);
        check("rd_busy", busy, 1);
        read_beats(a, len);
    endtask

    initial begin
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();

        // Fill whole array so every later read has a known expected value.
        for (int b = 0; b < DEPTH / 16; b++) do_write(b * 16, 15, -1, 0);

        // Directed: basic write/read, wrap, reject, stalled write.
        do_write(32'h010, 3, 32'hA1, 0);
        do_read(32'h010, 3);
        do_write(32'h3FE, 3, -1, 0);
        do_read(32'h3FE, 3);
        do_write(32'h400, 3, -1, 0);
        do_read(32'h400, 0);
        do_read(0, 1);
        do_write(32'h050, 1, 32'h5A, 3);
        do_read(32'h04F, 3);

        // Reset during the third beat of a 4-beat write.
        issue(1'b1, 32'h100, 3);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'(8'hC0 + i);
            model[32'h100 + i] = wr_data;
            step();
        end
        wr_valid = 1'b1;
        wr_data  = 8'hC2;
        rst = 1'b1;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_wr_ready", wr_ready, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_busy", busy, 0);
        step();
        rst = 1'b0;
        wr_valid = 1'b0;
        check("arst_no_done", done, 0);
        step();
        do_read(32'h100, 3);

        // Request held high through a read burst is accepted after done.
        issue(1'b0, 32'h200, 2);
        req_valid = 1'b1;
        check("hold_ready_busy", req_ready, 0);
        for (int i = 0; i <= 2; i++) begin
            step();
            check("hold_ready_lo", req_ready, 0);
            check("hold_rd_data", rd_data, model[32'h200 + i]);
            check("hold_done", done, (i == 2) ? 1 : 0);
        end
        step();
        check("hold_ready_hi", req_ready, 1);
        check("hold_idle", busy, 0);
        step();
        req_valid = 1'b0;
        check("hold_accepted", busy, 1);
        check("hold_rd_latency", rd_valid, 0);
        read_beats(32'h200, 2);

        // Random mix, including occasional out-of-range starts and wrap-around.
        for (int n = 0; n < 60; n++) begin
            int a;
            int len;
            a   = $urandom_range(0, DEPTH + 20);
            if ($urandom_range(0, 3) == 0) a = DEPTH - $urandom_range(1, 8);
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) do_write(a, len, -1, -1);
            else do_read(a, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
